fsm_control_param: RTL and testbench

- Parametrised multi-cycle control unit for the teaching CPU datapath. It sequences fetch, decode, operand load, ALU write-back, moves, I/O, jumps and halt.
- Successor to the 2-bit-opcode controller, with these additions:
  - opcode width is a parameter;
  - the opcode is latched at decode;
  - a memory-ready handshake with timeout;
  - JMP, IN, NOP and HLT instructions;
  - a sticky error state.
- Sits between instruction register and datapath enables/mux selects.

---
 rtl/fsm_control_pkg.sv | 36 +++
 rtl/mem_wait_timer.sv | 39 +++
 rtl/fsm_control_param.sv | 176 +++++++++++++++++
 tb/tb_fsm_control_param.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fsm_control_pkg.sv
// fsm_control_pkg: shared opcodes, state codes and datapath
// source selects for the multi-cycle control unit.
package fsm_control_pkg;

    localparam logic [2:0] OP_SUM = 3'd0;
    localparam logic [2:0] OP_RES = 3'd1;
    localparam logic [2:0] OP_MOV = 3'd2;
    localparam logic [2:0] OP_OUT = 3'd3;
    localparam logic [2:0] OP_JMP = 3'd4;
    localparam logic [2:0] OP_IN  = 3'd5;
    localparam logic [2:0] OP_NOP = 3'd6;
    localparam logic [2:0] OP_HLT = 3'd7;

    localparam int unsigned SRC_PC  = 0;
    localparam int unsigned SRC_OP1 = 1;
    localparam int unsigned SRC_OP2 = 2;
    localparam int unsigned SRC_ALU = 3;

    typedef enum logic [3:0] {
        S_INI = 4'd0,
        S_F   = 4'd1,
        S_D   = 4'd2,
        S_OP1 = 4'd3,
        S_OP2 = 4'd4,
        S_WC  = 4'd5,
        S_GA  = 4'd6,
        S_WB  = 4'd7,
        S_OA  = 4'd8,
        S_IA  = 4'd9,
        S_JP  = 4'd10,
        S_COU = 4'd11,
        S_HLT = 4'd12,
        S_ERR = 4'd13
    } state_t;

endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts cycles spent waiting for memory ready
// and flags a timeout when the count would reach WAIT_MAX.
module mem_wait_timer #(
    parameter int WAIT_MAX = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic mem_listo,
    output logic timeout
);

    localparam int CW = $clog2(WAIT_MAX + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [CW-1:0] cnt_inc;

    // Count only while stalled; leaving a wait state or ready clears it.
    always_comb begin
        cnt_inc = cnt_q + CW'(1);
        cnt_d   = '0;
        timeout = 1'b0;
        if (active && !mem_listo) begin
            cnt_d   = cnt_inc;
            timeout = (cnt_inc == CW'(WAIT_MAX));
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fsm_control_param.sv
// fsm_control_param: multi-cycle sequencer driving datapath enables
// and mux selects from the latched opcode and memory handshake.
module fsm_control_param
    import fsm_control_pkg::*;
#(
    parameter int OPW      = 3,
    parameter int SELW     = 2,
    parameter int WAIT_MAX = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [OPW-1:0]  operacion,
    input  logic            mem_listo,
    output logic            enmem,
    output logic            wrmem,
    output logic            enir,
    output logic            enrop1,
    output logic            enrop2,
    output logic            enrio,
    output logic            enpc,
    output logic            ldpc,
    output logic            seloper,
    output logic [SELW-1:0] selmux,
    output logic            halt,
    output logic            error,
    output logic [3:0]      estado
);

    state_t     state_q;
    state_t     state_d;
    logic [2:0] op_q;
    logic [2:0] op_d;
    logic       wait_act;
    logic       timeout;
    logic       op_bad;
    logic       is_res;

    // Any set bit above the decoded field makes the opcode illegal.
    always_comb begin
        op_bad = |(operacion >> 3);
    end

    // Memory-wait states share one timeout counter.
    always_comb begin
        wait_act = (state_q == S_F)  || (state_q == S_WC) ||
                   (state_q == S_WB) || (state_q == S_IA);
    end

    mem_wait_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .active    (wait_act),
        .mem_listo (mem_listo),
        .timeout   (timeout)
    );

    // Next-state logic; the opcode is captured only in decode.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        unique case (state_q)
            S_INI: state_d = S_F;
            S_F: begin
                if (mem_listo)    state_d = S_D;
                else if (timeout) state_d = S_ERR;
            end
            S_D: begin
                op_d = operacion[2:0];
                if (op_bad) begin
                    state_d = S_ERR;
                end else begin
                    unique case (operacion[2:0])
                        OP_SUM:  state_d = S_OP1;
                        OP_RES:  state_d = S_OP1;
                        OP_MOV:  state_d = S_GA;
                        OP_OUT:  state_d = S_OA;
                        OP_JMP:  state_d = S_JP;
                        OP_IN:   state_d = S_IA;
                        OP_NOP:  state_d = S_COU;
                        OP_HLT:  state_d = S_HLT;
                        default: state_d = S_ERR;
                    endcase
                end
            end
            S_OP1: state_d = S_OP2;
            S_OP2: state_d = S_WC;
            S_WC, S_WB, S_IA: begin
                if (mem_listo)    state_d = S_COU;
                else if (timeout) state_d = S_ERR;
            end
            S_GA:  state_d = S_WB;
            S_OA:  state_d = S_COU;
            S_JP:  state_d = S_F;
            S_COU: state_d = S_F;
            S_HLT: state_d = S_HLT;
            default: state_d = S_ERR;
        endcase
    end

    // State and latched opcode registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_INI;
            op_q    <= OP_SUM;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    // Moore decode from the state register; enir follows ready in fetch.
    always_comb begin
        is_res  = (op_q == OP_RES);
        enmem   = 1'b0;
        wrmem   = 1'b0;
        enir    = 1'b0;
        enrop1  = 1'b0;
        enrop2  = 1'b0;
        enrio   = 1'b0;
        enpc    = 1'b0;
        ldpc    = 1'b0;
        seloper = 1'b0;
        selmux  = SELW'(SRC_PC);
        halt    = 1'b0;
        error   = 1'b0;
        estado  = state_q;
        unique case (state_q)
            S_INI, S_D: ;
            S_F: begin
                enmem = 1'b1;
                enir  = mem_listo;
            end
            S_OP1, S_GA: begin
                enrop1 = 1'b1;
                selmux = SELW'(SRC_OP1);
            end
            S_OP2: begin
                enrop2  = 1'b1;
                selmux  = SELW'(SRC_OP2);
                seloper = is_res;
            end
            S_WC: begin
                enmem   = 1'b1;
                wrmem   = 1'b1;
                selmux  = SELW'(SRC_ALU);
                seloper = is_res;
            end
            S_WB: begin
                enmem  = 1'b1;
                wrmem  = 1'b1;
                selmux = SELW'(SRC_OP2);
            end
            S_OA: begin
                enrio  = 1'b1;
                selmux = SELW'(SRC_OP1);
            end
            S_IA: begin
                enmem = 1'b1;
                wrmem = 1'b1;
            end
            S_JP: begin
                ldpc   = 1'b1;
                selmux = SELW'(SRC_OP1);
            end
            S_COU: enpc = 1'b1;
            S_HLT: halt = 1'b1;
            default: begin
                error = 1'b1;
                halt  = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_fsm_control_param.sv
// tb_fsm_control_param: vector table plus hand sequences, with a
// per-cycle scoreboard of expected state and outputs.
module tb_fsm_control_param;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mem_listo = 1'b0;
    logic [2:0] operacion = 3'd0;

    logic enmem, wrmem, enir, enrop1, enrop2, enrio;
    logic enpc, ldpc, seloper, halt, error;
    logic [1:0] selmux;
    logic [3:0] estado;

    logic [3:0] operacion4 = 4'b1000;
    logic       ml4 = 1'b1;
    logic enmem4, wrmem4, enir4, enrop14, enrop24, enrio4;
    logic enpc4, ldpc4, seloper4, halt4, error4;
    logic [1:0] selmux4;
    logic [3:0] estado4;

    always #5 clk = ~clk;

    fsm_control_param dut (
        .clk(clk), .rst(rst), .operacion(operacion),
        .mem_listo(mem_listo), .enmem(enmem), .wrmem(wrmem),
        .enir(enir), .enrop1(enrop1), .enrop2(enrop2),
        .enrio(enrio), .enpc(enpc), .ldpc(ldpc),
        .seloper(seloper), .selmux(selmux), .halt(halt),
        .error(error), .estado(estado)
    );

    fsm_control_param #(.OPW(4), .SELW(2), .WAIT_MAX(15)) dut4 (
        .clk(clk), .rst(rst), .operacion(operacion4),
        .mem_listo(ml4), .enmem(enmem4), .wrmem(wrmem4),
        .enir(enir4), .enrop1(enrop14), .enrop2(enrop24),
        .enrio(enrio4), .enpc(enpc4), .ldpc(ldpc4),
        .seloper(seloper4), .selmux(selmux4), .halt(halt4),
        .error(error4), .estado(estado4)
    );

    typedef struct {
        logic [16:0] v;
        string       tag;
    } exp_t;

    typedef struct {
        logic [2:0] op;
        int         len;
        int         seq [6];
        string      name;
    } vec_t;

    exp_t sb[$];
    vec_t vq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Expected {estado, enmem, wrmem, enir, enrop1, enrop2, enrio,
    // enpc, ldpc, seloper, selmux[1:0], halt, error} per state.
    function automatic logic [16:0] ex(int s, logic res, logic ml);
        logic [12:0] o;
        logic [3:0]  st;
        o  = '0;
        st = 4'(s);
        case (s)
            1:  begin o[12] = 1'b1; o[10] = ml; end
            3:  begin o[9] = 1'b1; o[3:2] = 2'd1; end
            4:  begin o[8] = 1'b1; o[3:2] = 2'd2; o[4] = res; end
            5:  begin o[12] = 1'b1; o[11] = 1'b1; o[3:2] = 2'd3; o[4] = res; end
            6:  begin o[9] = 1'b1; o[3:2] = 2'd1; end
            7:  begin o[12] = 1'b1; o[11] = 1'b1; o[3:2] = 2'd2; end
            8:  begin o[7] = 1'b1; o[3:2] = 2'd1; end
            9:  begin o[12] = 1'b1; o[11] = 1'b1; end
            10: begin o[5] = 1'b1; o[3:2] = 2'd1; end
            11: o[6] = 1'b1;
            12: o[1] = 1'b1;
            13: begin o[1] = 1'b1; o[0] = 1'b1; end
            default: o = '0;
        endcase
        return {st, o};
    endfunction

    task automatic push(logic [16:0] v, string tag);
        exp_t e;
        e.v   = v;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic step(int st, logic ml, logic [2:0] op,
                        logic res, string tag);
        @(posedge clk);
        #1;
        mem_listo = ml;
        operacion = op;
        push(ex(st, res, ml), tag);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        mem_listo = 1'b0;
        push(ex(0, 1'b0, 1'b0), "rst_on");
        @(posedge clk);
        #1;
        push(ex(0, 1'b0, 1'b0), "rst_hold");
        @(posedge clk);
        #1;
        rst = 1'b0;
        push(ex(0, 1'b0, 1'b0), "rst_ini");
    endtask

    task automatic add(logic [2:0] op, int len, int a, int b, int c,
                       int d, int e, int f, string name);
        vec_t v;
        v.op   = op;
        v.len  = len;
        v.seq  = '{a, b, c, d, e, f};
        v.name = name;
        vq.push_back(v);
    endtask

    logic [16:0] obs;
    assign obs = {estado, enmem, wrmem, enir, enrop1, enrop2, enrio,
                  enpc, ldpc, seloper, selmux, halt, error};

    // Scoreboard pop away from the active edge.
    always @(negedge clk) begin : mon
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.tag, 32'(obs), 32'(e.v));
        end
    end

    // At most one register-load / PC enable in any cycle.
    always @(negedge clk) begin
        assert ($onehot0({enir, enrop1, enrop2, enrio, enpc, ldpc}))
        else begin
            n_bad++;
            $display("FAIL onehot: enables %b",
                     {enir, enrop1, enrop2, enrio, enpc, ldpc});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] opk;
        add(3'd0, 6, 1, 2, 3, 4, 5, 11, "sum");
        add(3'd1, 6, 1, 2, 3, 4, 5, 11, "res");
        add(3'd2, 5, 1, 2, 6, 7, 11, 0, "mov");
        add(3'd3, 4, 1, 2, 8, 11, 0, 0, "out");
        add(3'd5, 4, 1, 2, 9, 11, 0, 0, "in");
        add(3'd4, 3, 1, 2, 10, 0, 0, 0, "jmp");
        add(3'd6, 3, 1, 2, 11, 0, 0, 0, "nop");

        do_reset();
        foreach (vq[i]) begin
            for (int k = 0; k < vq[i].len; k++) begin
                opk = (k == 1) ? vq[i].op : ~vq[i].op;
                step(vq[i].seq[k], 1'b1, opk, vq[i].op == 3'd1,
                     $sformatf("%s_c%0d", vq[i].name, k));
            end
        end
        step(1, 1'b1, 3'd0, 1'b0, "tbl_back_f");

        // RES with a stalled write; opcode changes after decode.
        do_reset();
        step(1, 1'b1, 3'd7, 1'b0, "resw_f");
        step(2, 1'b1, 3'd1, 1'b0, "resw_d");
        step(3, 1'b1, 3'd0, 1'b1, "resw_op1");
        step(4, 1'b1, 3'd0, 1'b1, "resw_op2");
        for (int k = 0; k < 3; k++)
            step(5, 1'b0, 3'd0, 1'b1, $sformatf("resw_wc%0d", k));
        step(5, 1'b1, 3'd0, 1'b1, "resw_wc3");
        step(11, 1'b1, 3'd0, 1'b1, "resw_cou");
        step(1, 1'b1, 3'd0, 1'b1, "resw_f2");

        // Fetch timeout into a sticky error.
        do_reset();
        for (int k = 0; k < 15; k++)
            step(1, 1'b0, 3'd0, 1'b0, $sformatf("to_f%0d", k));
        for (int k = 0; k < 4; k++)
            step(13, k[0], 3'd3, 1'b0, $sformatf("to_err%0d", k));

        // Ready on the last allowed wait cycle still wins.
        do_reset();
        for (int k = 0; k < 14; k++)
            step(1, 1'b0, 3'd0, 1'b0, $sformatf("edge_f%0d", k));
        step(1, 1'b1, 3'd0, 1'b0, "edge_f14");
        step(2, 1'b1, 3'd6, 1'b0, "edge_d");
        step(11, 1'b1, 3'd0, 1'b0, "edge_cou");
        step(1, 1'b1, 3'd0, 1'b0, "edge_f");

        // Halt ignores later opcodes and ready toggling.
        do_reset();
        step(1, 1'b1, 3'd0, 1'b0, "hlt_f");
        step(2, 1'b1, 3'd7, 1'b0, "hlt_d");
        for (int k = 0; k < 5; k++)
            step(12, k[0], 3'd3, 1'b0, $sformatf("hlt_s%0d", k));

        // Asynchronous reset in the middle of a write.
        do_reset();
        step(1, 1'b1, 3'd7, 1'b0, "ar_f");
        step(2, 1'b1, 3'd0, 1'b0, "ar_d");
        step(3, 1'b1, 3'd0, 1'b0, "ar_op1");
        step(4, 1'b1, 3'd0, 1'b0, "ar_op2");
        step(5, 1'b0, 3'd0, 1'b0, "ar_wc0");
        step(5, 1'b0, 3'd0, 1'b0, "ar_wc1");
        @(negedge clk);
        #2;
        chk("ar_pre_enmem", 32'(enmem), 32'd1);
        rst = 1'b1;
        #1;
        chk("ar_enmem", 32'(enmem), 32'd0);
        chk("ar_wrmem", 32'(wrmem), 32'd0);
        chk("ar_estado", 32'(estado), 32'd0);
        @(posedge clk);
        #1;
        push(ex(0, 1'b0, 1'b0), "ar_hold");
        @(posedge clk);
        #1;
        rst = 1'b0;
        push(ex(0, 1'b0, 1'b0), "ar_ini");
        step(1, 1'b1, 3'd0, 1'b0, "ar_f2");
        step(2, 1'b1, 3'd4, 1'b0, "ar_d2");
        step(10, 1'b1, 3'd0, 1'b0, "ar_jp");
        step(1, 1'b1, 3'd0, 1'b0, "ar_f3");

        @(negedge clk);
        #1;
        chk("sb_drain", 32'(sb.size()), 32'd0);
        chk("opw4_estado", 32'(estado4), 32'd13);
        chk("opw4_error", 32'(error4), 32'd1);
        chk("opw4_halt", 32'(halt4), 32'd1);
        chk("opw4_enmem", 32'(enmem4), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
